// File: rtl/fp16_pkg.sv
// Shared FP16 field positions, constants and small helpers for the
// FP16 multiply datapath and its schedulers.
package fp16_pkg;

  typedef logic [15:0] fp16_t;

  localparam int    FP16_SIGN_BIT = 15;
  localparam int    FP16_EXP_MSB  = 14;
  localparam int    FP16_EXP_LSB  = 10;
  localparam int    FP16_MAN_MSB  = 9;
  localparam int    FP16_MAN_LSB  = 0;
  localparam fp16_t FP16_POS_ZERO = 16'h0000;
  localparam fp16_t FP16_NEG_ZERO = 16'h8000;

  // Exponent and mantissa both zero, sign ignored.
  function automatic logic fp16_is_zero(input fp16_t x);
    return (x[FP16_EXP_MSB:FP16_MAN_LSB] == 15'h0000);
  endfunction

  function automatic fp16_t fp16_signed_zero(input fp16_t a, input fp16_t b);
    return (a[FP16_SIGN_BIT] ^ b[FP16_SIGN_BIT]) ? FP16_NEG_ZERO : FP16_POS_ZERO;
  endfunction

endpackage

// File: rtl/multiplier_fp16.sv
// Combinational FP16 multiplier for normal operands: implicit leading one,
// truncated mantissa, no rounding, overflow or subnormal handling.
module multiplier_fp16
  import fp16_pkg::*;
(
  input  fp16_t i_a,
  input  fp16_t i_b,
  output fp16_t o_z
);

  logic [21:0] w_prod;
  logic [4:0]  w_exp;
  logic [9:0]  w_man;
  logic        w_unused_lsbs;

  assign w_prod = {11'd0, 1'b1, i_a[FP16_MAN_MSB:FP16_MAN_LSB]}
                * {11'd0, 1'b1, i_b[FP16_MAN_MSB:FP16_MAN_LSB]};

  // Product of two 1.x mantissas lies in [1,4); renormalise when bit 21 is set.
  assign w_exp = i_a[FP16_EXP_MSB:FP16_EXP_LSB] + i_b[FP16_EXP_MSB:FP16_EXP_LSB]
               - 5'd15 + {4'd0, w_prod[21]};
  assign w_man = w_prod[21] ? w_prod[20:11] : w_prod[19:10];
  assign o_z   = {i_a[FP16_SIGN_BIT] ^ i_b[FP16_SIGN_BIT], w_exp, w_man};

  assign w_unused_lsbs = ^w_prod[9:0];

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: scans requests starting at i_ptr and returns a one-hot
// grant plus its encoded index. Purely combinational.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [N-1:0]     o_gnt,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_any
);

  // First requester at or after the pointer, wrapping modulo N.
  always_comb begin
    logic [IDX_W-1:0] w_j;
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    w_j   = '0;
    for (int k = 0; k < N; k++) begin
      w_j = IDX_W'((int'(i_ptr) + k) % N);
      if (!o_any && i_req[w_j]) begin
        o_gnt[w_j] = 1'b1;
        o_idx      = w_j;
        o_any      = 1'b1;
      end else begin
        o_any = o_any;
      end
    end
  end

endmodule

// File: rtl/fp16_mul_arbiter.sv
// Shares one FP16 multiplier among NUM_REQ requesters: round-robin issue into
// an operand stage (S1), registered result stage (S2) with tagged backpressure.
module fp16_mul_arbiter
  import fp16_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int ID_W        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  parameter bit ZERO_BYPASS = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ*16-1:0] req_a,
  input  logic [NUM_REQ*16-1:0] req_b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [15:0]           out_z,
  output logic [ID_W-1:0]       out_id,
  output logic [1:0]            inflight,
  output logic                  idle
);

  logic            r_s1_valid;
  fp16_t           r_s1_a;
  fp16_t           r_s1_b;
  logic [ID_W-1:0] r_s1_id;
  logic            r_s1_zero;
  logic [ID_W-1:0] r_ptr;
  logic            r_out_valid;
  fp16_t           r_out_z;
  logic [ID_W-1:0] r_out_id;

  logic               w_s2_en;
  logic               w_s1_en;
  logic [NUM_REQ-1:0] w_gnt;
  logic [ID_W-1:0]    w_win;
  logic               w_any;
  logic               w_accept;
  fp16_t              w_win_a;
  fp16_t              w_win_b;
  logic               w_win_zero;
  logic [ID_W-1:0]    w_ptr_nxt;
  fp16_t              w_prod;
  fp16_t              w_result;

  // The whole pipe advances in the same cycle the consumer drains S2.
  assign w_s2_en = !r_out_valid | out_ready;
  assign w_s1_en = !r_s1_valid | w_s2_en;

  rr_arbiter #(.N(NUM_REQ), .IDX_W(ID_W)) u_arb (
    .i_req (req_valid),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_win),
    .o_any (w_any)
  );

  assign req_ready  = w_s1_en ? w_gnt : {NUM_REQ{1'b0}};
  assign w_accept   = w_s1_en & w_any;
  assign w_win_a    = req_a[{w_win, 4'd0} +: 16];
  assign w_win_b    = req_b[{w_win, 4'd0} +: 16];
  assign w_win_zero = ZERO_BYPASS && (fp16_is_zero(w_win_a) || fp16_is_zero(w_win_b));
  assign w_ptr_nxt  = (w_win == ID_W'(NUM_REQ - 1)) ? {ID_W{1'b0}} : w_win + ID_W'(1);

  multiplier_fp16 u_mul (
    .i_a (r_s1_a),
    .i_b (r_s1_b),
    .o_z (w_prod)
  );

  assign w_result = r_s1_zero ? fp16_signed_zero(r_s1_a, r_s1_b) : w_prod;

  // Operand stage and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_a     <= FP16_POS_ZERO;
      r_s1_b     <= FP16_POS_ZERO;
      r_s1_id    <= {ID_W{1'b0}};
      r_s1_zero  <= 1'b0;
      r_ptr      <= {ID_W{1'b0}};
    end else if (w_s1_en) begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_a    <= w_win_a;
        r_s1_b    <= w_win_b;
        r_s1_id   <= w_win;
        r_s1_zero <= w_win_zero;
        r_ptr     <= w_ptr_nxt;
      end
    end
  end

  // Result stage; contents frozen while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_z     <= FP16_POS_ZERO;
      r_out_id    <= {ID_W{1'b0}};
    end else if (w_s2_en) begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_out_z  <= w_result;
        r_out_id <= r_s1_id;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_z     = r_out_z;
  assign out_id    = r_out_id;
  assign inflight  = {1'b0, r_s1_valid} + {1'b0, r_out_valid};
  assign idle      = !r_s1_valid && !r_out_valid;

endmodule
